adsr_pulse_voice: RTL and testbench
===================================

Name: adsr_pulse_voice

Overview:
Parametrised successor to the fixed 20-step decaying square voice. Produces a pulse-family tone (50%, 25% or 12.5% duty) from a per-note period, shaped by a gated ADSR envelope instead of a fixed intra-period amplitude ramp. One instance drives one voice into the audio mixer. It runs directly on the system audio clock.

Parameters:
OUT_W, 32, signed output sample width
PERIOD_W, 32, period input / phase counter width, in clock cycles
PEAK, 300000000, full-scale wave magnitude; must satisfy PEAK < 2^(OUT_W-1)
ENV_W, 8, envelope level width; ENV_MAX = 2^ENV_W - 1
ENV_DIV, 50000, clock cycles per envelope tick
ATTACK_STEP, 4, level increment per tick in ATTACK
DECAY_STEP, 1, level decrement per tick in DECAY
RELEASE_STEP, 2, level decrement per tick in RELEASE

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
gate  in  1  key held; a rising edge triggers the note, a falling edge releases it
period  in  PERIOD_W  tone period in cycles; latched on gate rise
mode  in  2  0 = 50% duty, 1 = 25%, 2 = 12.5%, 3 = silent; latched on gate rise
sustain_level  in  ENV_W  sustain level; latched on gate rise
audio_out  out  OUT_W  signed sample, registered
env_level  out  ENV_W  current envelope level
active  out  1  high whenever state != IDLE
cycle_start  out  1  one-cycle pulse when phase == 0 while active

Behaviour:
- Reset (reset == 0, asynchronous): state IDLE; level, phase, prescaler, latched regs, audio_out, cycle_start all 0.
- Gate edge detection uses a registered gate_q. rise = gate & ~gate_q; fall = ~gate & gate_q.
- On rise, in any state:
  - latch period_q = max(period, 2), mode_q, sus_q.
  - phase <= 0; state <= ATTACK.
  - level is kept, so a retrigger does not click.
- Phase counter, when not IDLE: phase increments each cycle; when phase == period_q-1 it wraps to 0.
- Wave sample:
  - threshold = period_q>>1 (mode 0), >>2 (mode 1), >>3 (mode 2).
  - sample = +PEAK when phase < threshold, else -PEAK.
  - mode 3 gives sample 0.
  - If threshold == 0, sample is -PEAK.
- Envelope prescaler: free-running 0..ENV_DIV-1 from reset; tick = (prescaler == ENV_DIV-1).
- State machine (transitions on tick unless stated):
  - IDLE: level 0; leaves only on rise.
  - ATTACK: level <= min(level+ATTACK_STEP, ENV_MAX); at ENV_MAX -> DECAY.
  - DECAY: level <= max(level-DECAY_STEP, sus_q); at sus_q -> SUSTAIN. If level <= sus_q on entry, go to SUSTAIN on the next tick and keep level.
  - SUSTAIN: hold level.
  - RELEASE: level <= max(level-RELEASE_STEP, 0); at 0 -> IDLE.
  - fall in ATTACK/DECAY/SUSTAIN -> RELEASE on the next clock, without waiting for a tick.
  - Simultaneous fall and tick: the transition to RELEASE wins; level is unchanged that cycle.
- Level arithmetic: computed at ENV_W+1 bits before clamping; no wrap-around.
- Output: audio_out <= (sample * level) >>> ENV_W.
  - Signed multiply at OUT_W+ENV_W+1 bits; the arithmetic shift floors.
  - Registered, so audio_out lags phase/level by 1 cycle.
  - audio_out is 0 in the cycle after entering IDLE.
- period and mode changes while gate is held are ignored until the next rise.
- A reset during a note aborts it immediately; gate_q clears, so a gate still held after reset counts as a new rise.

Decomposition:
- Package adsr_pkg holds:
  - env_state_t enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE)
  - mode codes MODE_P50 / MODE_P25 / MODE_P12 / MODE_OFF
- Sub-module adsr_envelope holds the prescaler, FSM and level, with ports gate/tick-params/sus in and level/state out.
- The top level holds the phase counter, sample select, multiply and output register.

Test Plan:
Bench parameters: OUT_W=16, ENV_W=4, ENV_DIV=4, PEAK=1000, ATTACK_STEP=5, DECAY_STEP=1, RELEASE_STEP=3.
- Reset with gate high and period=8 -> all outputs 0; after reset releases, rise detected next cycle, active=1, env_level 5,10,15 on successive ticks, then DECAY.
- sustain_level=12 -> levels 14,13,12, then SUSTAIN holding 12; mode 0 gives audio_out +750 for 4 cycles then -750 for 4, with cycle_start every 8 cycles.
- Level 15 held (sustain 15), mode 0 -> audio_out +937 high and -938 low; mode 1 -> +937 for 2 cycles, -938 for 6; mode 3 -> 0.
- Gate falls in SUSTAIN at level 12 -> RELEASE next clock; levels 9,6,3,0 over 4 ticks; IDLE, active=0, audio_out 0.
- Retrigger in RELEASE at level 6 -> ATTACK from 6 (11, 15); phase restarts at 0; new period latched; period=0 behaves as 2.
- Fall in the same cycle as a tick during ATTACK at level 10 -> RELEASE with level still 10; next tick gives 7.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR pulse voice: envelope states,
// duty-mode codes and the duty-to-threshold shift helper.
package adsr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [1:0] MODE_P50 = 2'd0;
    localparam logic [1:0] MODE_P25 = 2'd1;
    localparam logic [1:0] MODE_P12 = 2'd2;
    localparam logic [1:0] MODE_OFF = 2'd3;

    // High-phase length is period >> shift: 1 -> 50%, 2 -> 25%, 3 -> 12.5%.
    function automatic logic [1:0] duty_shift(input logic [1:0] mode);
        logic [1:0] shift;
        case (mode)
            MODE_P50: shift = 2'd1;
            MODE_P25: shift = 2'd2;
            MODE_P12: shift = 2'd3;
            default:  shift = 2'd3;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/adsr_envelope.sv
// Gated ADSR envelope: free-running tick prescaler, state machine and level.
// Gate edges arrive pre-detected; a rise always restarts ATTACK from the current level.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int ENV_W        = 8,
    parameter int ENV_DIV      = 50000,
    parameter int ATTACK_STEP  = 4,
    parameter int DECAY_STEP   = 1,
    parameter int RELEASE_STEP = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             gate_rise,
    input  logic             gate_fall,
    input  logic [ENV_W-1:0] sus_level,
    output logic [ENV_W-1:0] level,
    output env_state_t       state
);

    localparam int               PRE_W     = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(ENV_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_ZERO  = {PRE_W{1'b0}};
    localparam logic [ENV_W-1:0] LVL_ZERO  = {ENV_W{1'b0}};
    localparam logic [ENV_W-1:0] LVL_MAX   = {ENV_W{1'b1}};
    localparam logic [ENV_W:0]   LVL_MAX_X = {1'b0, {ENV_W{1'b1}}};
    localparam logic [ENV_W:0]   ATT_X     = (ENV_W+1)'(ATTACK_STEP);
    localparam logic [ENV_W:0]   DEC_X     = (ENV_W+1)'(DECAY_STEP);
    localparam logic [ENV_W:0]   REL_X     = (ENV_W+1)'(RELEASE_STEP);

    logic [PRE_W-1:0] pre_r;
    logic             tick_s;
    env_state_t       state_r;
    env_state_t       state_nxt_s;
    logic [ENV_W-1:0] level_r;
    logic [ENV_W-1:0] level_nxt_s;
    logic [ENV_W:0]   lvl_x_s;
    logic [ENV_W:0]   sus_x_s;
    logic [ENV_W:0]   up_x_s;

    // Envelope tick prescaler, free-running from reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_r <= PRE_ZERO;
        end else if (pre_r == PRE_LAST) begin
            pre_r <= PRE_ZERO;
        end else begin
            pre_r <= pre_r + PRE_ONE;
        end
    end

    assign tick_s = (pre_r == PRE_LAST);

    // Level operands widened by one bit so the step arithmetic cannot wrap.
    always_comb begin
        lvl_x_s = {1'b0, level_r};
        sus_x_s = {1'b0, sus_level};
        up_x_s  = lvl_x_s + ATT_X;
    end

    // State and level registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            level_r <= LVL_ZERO;
        end else begin
            state_r <= state_nxt_s;
            level_r <= level_nxt_s;
        end
    end

    // Next state and level: rise beats fall beats tick; a fall freezes the level.
    always_comb begin
        state_nxt_s = state_r;
        level_nxt_s = level_r;
        if (gate_rise) begin
            state_nxt_s = ATTACK;
        end else if (gate_fall &&
                     ((state_r == ATTACK) || (state_r == DECAY) || (state_r == SUSTAIN))) begin
            state_nxt_s = RELEASE;
        end else if (tick_s) begin
            case (state_r)
                IDLE: begin
                    level_nxt_s = LVL_ZERO;
                end
                ATTACK: begin
                    if (up_x_s >= LVL_MAX_X) begin
                        level_nxt_s = LVL_MAX;
                        state_nxt_s = DECAY;
                    end else begin
                        level_nxt_s = ENV_W'(up_x_s);
                    end
                end
                DECAY: begin
                    if (lvl_x_s <= sus_x_s) begin
                        state_nxt_s = SUSTAIN;
                    end else if ((lvl_x_s - sus_x_s) > DEC_X) begin
                        level_nxt_s = ENV_W'(lvl_x_s - DEC_X);
                    end else begin
                        level_nxt_s = sus_level;
                        state_nxt_s = SUSTAIN;
                    end
                end
                SUSTAIN: begin
                    level_nxt_s = level_r;
                end
                RELEASE: begin
                    if (lvl_x_s > REL_X) begin
                        level_nxt_s = ENV_W'(lvl_x_s - REL_X);
                    end else begin
                        level_nxt_s = LVL_ZERO;
                        state_nxt_s = IDLE;
                    end
                end
                default: begin
                    level_nxt_s = LVL_ZERO;
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            level_nxt_s = level_r;
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        level = level_r;
        state = state_r;
    end

endmodule

// File: rtl/adsr_pulse_voice_chk.sv
// Invariant checker for the pulse voice: legal states, silent IDLE,
// and a phase that never leaves the latched period.
module adsr_pulse_voice_chk
    import adsr_pkg::*;
#(
    parameter int PERIOD_W = 32,
    parameter int ENV_W    = 8
) (
    input logic                clock,
    input logic                reset,
    input env_state_t          state,
    input logic [ENV_W-1:0]    level,
    input logic [PERIOD_W-1:0] phase,
    input logic [PERIOD_W-1:0] period_q
);

    a_state_legal: assert property (@(posedge clock) disable iff (!reset)
        state inside {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE});

    a_idle_silent: assert property (@(posedge clock) disable iff (!reset)
        (state == IDLE) |-> (level == {ENV_W{1'b0}}));

    a_phase_range: assert property (@(posedge clock) disable iff (!reset)
        (state != IDLE) |-> (phase < period_q));

endmodule

// File: rtl/adsr_pulse_voice.sv
// One pulse-family voice (50/25/12.5% duty) shaped by a gated ADSR envelope.
// Note parameters are latched on gate rise; the output sample is registered.
module adsr_pulse_voice
    import adsr_pkg::*;
#(
    parameter int OUT_W        = 32,
    parameter int PERIOD_W     = 32,
    parameter int PEAK         = 300000000,
    parameter int ENV_W        = 8,
    parameter int ENV_DIV      = 50000,
    parameter int ATTACK_STEP  = 4,
    parameter int DECAY_STEP   = 1,
    parameter int RELEASE_STEP = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    gate,
    input  logic [PERIOD_W-1:0]     period,
    input  logic [1:0]              mode,
    input  logic [ENV_W-1:0]        sustain_level,
    output logic signed [OUT_W-1:0] audio_out,
    output logic [ENV_W-1:0]        env_level,
    output logic                    active,
    output logic                    cycle_start
);

    localparam int                      PROD_W   = OUT_W + ENV_W + 1;
    localparam logic [PERIOD_W-1:0]     PER_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0]     PER_ONE  = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0]     PER_MIN  = PERIOD_W'(2);
    localparam logic [ENV_W-1:0]        LVL_ZERO = {ENV_W{1'b0}};
    localparam logic signed [OUT_W-1:0] PEAK_POS = OUT_W'(PEAK);
    localparam logic signed [OUT_W-1:0] PEAK_NEG = -PEAK_POS;
    localparam logic signed [OUT_W-1:0] OUT_ZERO = {OUT_W{1'b0}};

    logic                     gate_q_r;
    logic                     rise_s;
    logic                     fall_s;
    logic [PERIOD_W-1:0]      period_q_r;
    logic [1:0]               mode_q_r;
    logic [ENV_W-1:0]         sus_q_r;
    logic [PERIOD_W-1:0]      phase_r;
    logic [PERIOD_W-1:0]      thresh_s;
    logic signed [OUT_W-1:0]  sample_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [OUT_W-1:0]  audio_r;
    logic                     cycle_start_r;
    logic [ENV_W-1:0]         env_level_s;
    env_state_t               env_state_s;
    logic                     active_s;

    assign rise_s = gate & ~gate_q_r;
    assign fall_s = ~gate & gate_q_r;

    // Gate history and per-note parameters; a too-short period is raised to 2.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gate_q_r   <= 1'b0;
            period_q_r <= PER_ZERO;
            mode_q_r   <= MODE_P50;
            sus_q_r    <= LVL_ZERO;
        end else begin
            gate_q_r <= gate;
            if (rise_s) begin
                period_q_r <= (period < PER_MIN) ? PER_MIN : period;
                mode_q_r   <= mode;
                sus_q_r    <= sustain_level;
            end
        end
    end

    adsr_envelope #(
        .ENV_W        (ENV_W),
        .ENV_DIV      (ENV_DIV),
        .ATTACK_STEP  (ATTACK_STEP),
        .DECAY_STEP   (DECAY_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_env (
        .clock     (clock),
        .reset     (reset),
        .gate_rise (rise_s),
        .gate_fall (fall_s),
        .sus_level (sus_q_r),
        .level     (env_level_s),
        .state     (env_state_s)
    );

    assign active_s = (env_state_s != IDLE);

    // Phase counter restarts on every rise and parks at zero while idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_r <= PER_ZERO;
        end else if (rise_s) begin
            phase_r <= PER_ZERO;
        end else if (!active_s) begin
            phase_r <= PER_ZERO;
        end else if (phase_r == (period_q_r - PER_ONE)) begin
            phase_r <= PER_ZERO;
        end else begin
            phase_r <= phase_r + PER_ONE;
        end
    end

    // Pulse sample; a zero threshold falls through to the low half.
    always_comb begin
        thresh_s = period_q_r >> duty_shift(mode_q_r);
        if (!active_s || (mode_q_r == MODE_OFF)) begin
            sample_s = OUT_ZERO;
        end else if (phase_r < thresh_s) begin
            sample_s = PEAK_POS;
        end else begin
            sample_s = PEAK_NEG;
        end
    end

    assign prod_s = $signed({{(ENV_W+1){sample_s[OUT_W-1]}}, sample_s})
                  * $signed({{(OUT_W+1){1'b0}}, env_level_s});

    // Output register; the arithmetic shift floors negative products.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            audio_r       <= OUT_ZERO;
            cycle_start_r <= 1'b0;
        end else begin
            audio_r       <= OUT_W'(prod_s >>> ENV_W);
            cycle_start_r <= active_s && (phase_r == PER_ZERO);
        end
    end

    assign audio_out   = audio_r;
    assign cycle_start = cycle_start_r;
    assign env_level   = env_level_s;
    assign active      = active_s;

    adsr_pulse_voice_chk #(
        .PERIOD_W (PERIOD_W),
        .ENV_W    (ENV_W)
    ) u_chk (
        .clock    (clock),
        .reset    (reset),
        .state    (env_state_s),
        .level    (env_level_s),
        .phase    (phase_r),
        .period_q (period_q_r)
    );

endmodule

// File: tb/tb_adsr_pulse_voice.sv
// Self-checking bench for adsr_pulse_voice: directed note scenarios followed by
// random notes, all compared cycle by cycle against a behavioural voice model.
module tb_adsr_pulse_voice;

    localparam int OUT_W    = 16;
    localparam int PERIOD_W = 16;
    localparam int PEAK     = 1000;
    localparam int ENV_W    = 4;
    localparam int ENV_DIV  = 4;
    localparam int AS       = 5;
    localparam int DS       = 1;
    localparam int RS       = 3;
    localparam int ENV_MAX  = 15;
    localparam int LSCALE   = 16;

    localparam int S_IDLE = 0;
    localparam int S_ATT  = 1;
    localparam int S_DEC  = 2;
    localparam int S_SUS  = 3;
    localparam int S_REL  = 4;

    logic                    clock;
    logic                    reset;
    logic                    gate;
    logic [PERIOD_W-1:0]     period;
    logic [1:0]              mode;
    logic [ENV_W-1:0]        sustain_level;
    logic signed [OUT_W-1:0] audio_out;
    logic [ENV_W-1:0]        env_level;
    logic                    active;
    logic                    cycle_start;

    int n_vec;
    int n_miss;

    int m_state;
    int m_level;
    int m_phase;
    int m_period;
    int m_mode;
    int m_sus;
    int m_pre;
    int m_audio;
    bit m_gate_q;
    bit m_cs;

    adsr_pulse_voice #(
        .OUT_W        (OUT_W),
        .PERIOD_W     (PERIOD_W),
        .PEAK         (PEAK),
        .ENV_W        (ENV_W),
        .ENV_DIV      (ENV_DIV),
        .ATTACK_STEP  (AS),
        .DECAY_STEP   (DS),
        .RELEASE_STEP (RS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .gate          (gate),
        .period        (period),
        .mode          (mode),
        .sustain_level (sustain_level),
        .audio_out     (audio_out),
        .env_level     (env_level),
        .active        (active),
        .cycle_start   (cycle_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int floor_scale(input int p);
        if (p >= 0) return p / LSCALE;
        else        return -((-p + LSCALE - 1) / LSCALE);
    endfunction

    task automatic model_reset();
        m_state  = S_IDLE;
        m_level  = 0;
        m_phase  = 0;
        m_period = 0;
        m_mode   = 0;
        m_sus    = 0;
        m_pre    = 0;
        m_audio  = 0;
        m_gate_q = 1'b0;
        m_cs     = 1'b0;
    endtask

    // Advance the model over one clock edge using the inputs currently applied.
    task automatic model_step();
        bit rise;
        bit fall;
        bit tk;
        int smp;
        int thr;
        rise = gate && !m_gate_q;
        fall = !gate && m_gate_q;
        tk   = (m_pre == ENV_DIV - 1);
        if (m_state == S_IDLE || m_mode == 3) begin
            smp = 0;
        end else begin
            thr = m_period / (2 << m_mode);
            smp = (m_phase < thr) ? PEAK : -PEAK;
        end
        m_audio = floor_scale(smp * m_level);
        m_cs    = (m_state != S_IDLE) && (m_phase == 0);
        if (rise || m_state == S_IDLE) m_phase = 0;
        else                           m_phase = (m_phase + 1) % m_period;
        if (rise) begin
            m_period = (int'(period) < 2) ? 2 : int'(period);
            m_mode   = int'(mode);
            m_sus    = int'(sustain_level);
            m_state  = S_ATT;
        end else if (fall && (m_state == S_ATT || m_state == S_DEC || m_state == S_SUS)) begin
            m_state = S_REL;
        end else if (tk) begin
            case (m_state)
                S_ATT: begin
                    m_level = (m_level + AS > ENV_MAX) ? ENV_MAX : m_level + AS;
                    if (m_level == ENV_MAX) m_state = S_DEC;
                end
                S_DEC: begin
                    if (m_level <= m_sus) begin
                        m_state = S_SUS;
                    end else begin
                        m_level = (m_level - DS < m_sus) ? m_sus : m_level - DS;
                        if (m_level == m_sus) m_state = S_SUS;
                    end
                end
                S_REL: begin
                    m_level = (m_level - RS < 0) ? 0 : m_level - RS;
                    if (m_level == 0) m_state = S_IDLE;
                end
                default: ;
            endcase
        end
        m_pre    = (m_pre + 1) % ENV_DIV;
        m_gate_q = gate;
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
        check_val("audio_out", audio_out, m_audio);
        check_val("env_level", env_level, m_level);
        check_val("active", active, (m_state != S_IDLE) ? 1 : 0);
        check_val("cycle_start", cycle_start, m_cs ? 1 : 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check_val("rst_audio", audio_out, 0);
        check_val("rst_level", env_level, 0);
        check_val("rst_active", active, 0);
        check_val("rst_cycle_start", cycle_start, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic run_until_idle(input int limit);
        int i;
        i = 0;
        while (active && i < limit) begin
            step();
            i++;
        end
    endtask

    task automatic end_note();
        gate = 1'b0;
        step();
        run_until_idle(100);
        step();
    endtask

    initial begin
        int i;
        n_vec         = 0;
        n_miss        = 0;
        reset         = 1'b0;
        gate          = 1'b1;
        period        = PERIOD_W'(8);
        mode          = 2'd0;
        sustain_level = 4'd12;
        model_reset();
        #2;
        apply_reset();

        // Attack 5/10/15, decay to 12, then hold at +-750.
        repeat (40) step();
        check_val("sus_hold", env_level, 12);
        check_val("sus_mag", (audio_out < 0) ? -audio_out : audio_out, 750);

        // Release to idle; the cycle after entering IDLE is silent.
        end_note();
        check_val("idle_active", active, 0);
        check_val("idle_audio", audio_out, 0);

        // Full-scale sustain in modes 0, 1 and the silent mode.
        sustain_level = 4'd15;
        gate = 1'b1;
        repeat (40) step();
        check_val("full_level", env_level, 15);
        end_note();
        mode = 2'd1;
        gate = 1'b1;
        repeat (40) step();
        end_note();
        mode = 2'd3;
        gate = 1'b1;
        repeat (30) step();
        check_val("silent_audio", audio_out, 0);
        end_note();

        // Retrigger mid-release at level 6 with period 0.
        mode          = 2'd0;
        sustain_level = 4'd12;
        gate          = 1'b1;
        repeat (40) step();
        gate = 1'b0;
        i = 0;
        while (env_level != 4'd6 && i < 40) begin
            step();
            i++;
        end
        check_val("rel_at6", env_level, 6);
        period = PERIOD_W'(0);
        gate   = 1'b1;
        repeat (16) step();
        end_note();

        // Gate fall on the same edge as an attack tick at level 10.
        period = PERIOD_W'(8);
        gate   = 1'b1;
        i = 0;
        while (env_level != 4'd10 && i < 40) begin
            step();
            i++;
        end
        check_val("att_at10", env_level, 10);
        i = 0;
        while (m_pre != ENV_DIV - 1 && i < 8) begin
            step();
            i++;
        end
        gate = 1'b0;
        step();
        check_val("fall_tick_keep", env_level, 10);
        repeat (4) step();
        check_val("fall_tick_next", env_level, 7);
        run_until_idle(100);
        step();

        // Random notes, with one asynchronous reset in the middle of a note.
        for (int n = 0; n < 30; n++) begin
            period        = PERIOD_W'($urandom_range(0, 12));
            mode          = 2'($urandom_range(0, 3));
            sustain_level = ENV_W'($urandom_range(0, 15));
            gate          = 1'b1;
            repeat ($urandom_range(1, 60)) step();
            if (n == 15) begin
                apply_reset();
                repeat ($urandom_range(1, 20)) step();
            end
            gate = 1'b0;
            repeat ($urandom_range(1, 40)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
